// File: rtl/stream_pkg.sv
// Shared stream types and widths for the audio sample path.
package stream_pkg;

  localparam int STREAM_DATA_W = 32;

  typedef struct packed {
    logic [STREAM_DATA_W-1:0] data;
    logic                     last;
  } beat_t;

endpackage

// File: rtl/stream_fifo_mem.sv
// Storage array for stream_fifo: one synchronous write port, one asynchronous read port.
module stream_fifo_mem #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are deliberately left unreset; occupancy tracking makes stale entries invisible.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// Multi-entry valid/ready stream FIFO with first-word fall-through and a last delimiter.
// Optional store-and-forward packet mode is enabled by defining STREAM_FIFO_PKT_MODE_EN.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int DATA_W = STREAM_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic             s_ready_q, s_ready_d;
  logic             push, pop;
  logic [DATA_W:0]  rd_word;

  assign push = s_valid && s_ready_q;
  assign pop  = m_valid && m_ready;

  // s_ready looks at the post-update level, so a pop while full reopens the input one cycle later.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d   = level_q + CNT_W'(push) - CNT_W'(pop);
    s_ready_d = (level_d < FULL_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      s_ready_q <= s_ready_d;
    end
  end

  stream_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data ({s_last, s_data}),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );

  assign {m_last, m_data} = rd_word;
  assign s_ready          = s_ready_q;
  assign level            = level_q;

`ifdef STREAM_FIFO_PKT_MODE_EN
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

  always_comb begin
    pkt_count_d = pkt_count_q + CNT_W'(push && s_last) - CNT_W'(pop && m_last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  // A full FIFO with no complete packet drains cut-through so oversize packets cannot deadlock.
  assign m_valid   = (level_q != '0) && ((pkt_count_q != '0) || (level_q == FULL_LEVEL));
  assign pkt_count = pkt_count_q;
`else
  assign m_valid   = (level_q != '0);
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo (default DEPTH=8, DATA_W=32).
module tb_stream_fifo;
  import stream_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [31:0]      s_data = '0;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [31:0]      m_data;
  logic             m_last;
  logic [CNT_W-1:0] level;
  logic [CNT_W-1:0] pkt_count;

  int checks = 0;
  int failures = 0;

  beat_t q[$];
  logic  exp_s_ready = 1'b0;

  stream_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .level     (level),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int exp_pkts();
    int n = 0;
`ifdef STREAM_FIFO_PKT_MODE_EN
    foreach (q[i]) if (q[i].last) n++;
`endif
    return n;
  endfunction

  function automatic logic exp_m_valid();
    if (q.size() == 0) return 1'b0;
`ifdef STREAM_FIFO_PKT_MODE_EN
    return (exp_pkts() != 0) || (q.size() == DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  // Model update across one rising edge; inputs are sampled as they stand before the edge.
  task automatic tick();
    logic  push, pop;
    beat_t b;
    push = s_valid && exp_s_ready;
    pop  = exp_m_valid() && m_ready;
    b.data = s_data;
    b.last = s_last;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      exp_s_ready = 1'b0;
    end else begin
      if (pop) q.delete(0);
      if (push) q.push_back(b);
      exp_s_ready = (q.size() < DEPTH);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_s_ready got=%0b exp=0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid got=%0b exp=0", m_valid); end
    checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
    checks++; if (pkt_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL release_s_ready_early got=%0b exp=0", s_ready); end
    tick();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_s_ready got=%0b exp=1", s_ready); end
  endtask

  task automatic test_smoke();
    beat_t src[$];
    beat_t b;
    int    base[3] = '{32'h1000, 32'h2000, 32'h3000};
    int    len[3]  = '{3, 1, 5};
    int    got = 0;
    int    cyc = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < len[p]; k++) begin
        b.data = 32'(base[p] + k);
        b.last = (k == len[p] - 1);
        src.push_back(b);
      end
    end
    m_ready = 1'b1;
    while ((src.size() != 0 || q.size() != 0) && cyc < 60) begin
      s_valid = (src.size() != 0);
      if (s_valid) begin s_data = src[0].data; s_last = src[0].last; end
      #1;
      checks++; if (m_valid !== exp_m_valid()) begin failures++; $display("[TB] FAIL smoke_m_valid got=%0b exp=%0b", m_valid, exp_m_valid()); end
      checks++; if (s_ready !== exp_s_ready) begin failures++; $display("[TB] FAIL smoke_s_ready got=%0b exp=%0b", s_ready, exp_s_ready); end
      checks++; if (level !== CNT_W'(q.size())) begin failures++; $display("[TB] FAIL smoke_level got=%0d exp=%0d", level, q.size()); end
      checks++; if (pkt_count !== CNT_W'(exp_pkts())) begin failures++; $display("[TB] FAIL smoke_pkt_count got=%0d exp=%0d", pkt_count, exp_pkts()); end
`ifndef STREAM_FIFO_PKT_MODE_EN
      checks++; if (level > 4'd1) begin failures++; $display("[TB] FAIL smoke_level_max got=%0d exp<=1", level); end
`endif
      if (exp_m_valid() && m_ready) begin
        got++;
        checks++; if (m_data !== q[0].data || m_last !== q[0].last) begin failures++; $display("[TB] FAIL smoke_beat got=%h/%0b exp=%h/%0b", m_data, m_last, q[0].data, q[0].last); end
      end
      if (s_valid && exp_s_ready) src.delete(0);
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    checks++; if (got !== 9) begin failures++; $display("[TB] FAIL smoke_count got=%0d exp=9", got); end
  endtask

  task automatic test_fill_drain();
    int got = 0;
    int cyc = 0;
    int accept_cyc = -1;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hA0 + 32'(i);
      s_last  = (i == 7);
      #1;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_s_ready idx=%0d got=%0b exp=1", i, s_ready); end
      tick();
    end
    s_data = 32'hA8;
    s_last = 1'b1;
    #1;
    checks++; if (level !== 4'd8) begin failures++; $display("[TB] FAIL full_level got=%0d exp=8", level); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_s_ready got=%0b exp=0", s_ready); end
    checks++; if (m_valid !== 1'b1 || m_data !== 32'hA0) begin failures++; $display("[TB] FAIL full_head got=%0b/%h exp=1/a0", m_valid, m_data); end
    tick();
    checks++; if (level !== 4'd8 || s_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_hold got=%0d/%0b exp=8/0", level, s_ready); end
    m_ready = 1'b1;
    while ((s_valid || q.size() != 0) && cyc < 30) begin
      #1;
      checks++; if (m_valid !== exp_m_valid()) begin failures++; $display("[TB] FAIL drain_m_valid got=%0b exp=%0b", m_valid, exp_m_valid()); end
      checks++; if (s_ready !== exp_s_ready) begin failures++; $display("[TB] FAIL drain_s_ready got=%0b exp=%0b", s_ready, exp_s_ready); end
      checks++; if (level !== CNT_W'(q.size())) begin failures++; $display("[TB] FAIL drain_level got=%0d exp=%0d", level, q.size()); end
      if (exp_m_valid() && m_ready) begin
        got++;
        checks++; if (m_data !== q[0].data || m_last !== q[0].last) begin failures++; $display("[TB] FAIL drain_beat got=%h/%0b exp=%h/%0b", m_data, m_last, q[0].data, q[0].last); end
      end
      if (s_valid && exp_s_ready) accept_cyc = cyc;
      tick();
      if (accept_cyc == cyc) s_valid = 1'b0;
      cyc++;
    end
    s_valid = 1'b0;
    checks++; if (accept_cyc !== 1) begin failures++; $display("[TB] FAIL ninth_accept_cycle got=%0d exp=1", accept_cyc); end
    checks++; if (got !== 9) begin failures++; $display("[TB] FAIL drain_count got=%0d exp=9", got); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic acc;
    s_valid = 1'b0;
    while ((sent < 20 || s_valid || q.size() != 0) && cyc < 400) begin
      if (!s_valid && sent < 20 && $urandom_range(0, 9) < 7) begin
        s_valid = 1'b1;
        s_data  = 32'hC000 + 32'(sent);
        s_last  = (sent % 4 == 3);
      end
      m_ready = ($urandom_range(0, 1) == 1);
      #1;
      checks++; if (m_valid !== exp_m_valid()) begin failures++; $display("[TB] FAIL wrap_m_valid got=%0b exp=%0b", m_valid, exp_m_valid()); end
      checks++; if (s_ready !== exp_s_ready) begin failures++; $display("[TB] FAIL wrap_s_ready got=%0b exp=%0b", s_ready, exp_s_ready); end
      checks++; if (level !== CNT_W'(q.size()) || level > 4'd8) begin failures++; $display("[TB] FAIL wrap_level got=%0d exp=%0d", level, q.size()); end
      checks++; if (pkt_count !== CNT_W'(exp_pkts())) begin failures++; $display("[TB] FAIL wrap_pkt_count got=%0d exp=%0d", pkt_count, exp_pkts()); end
      if (exp_m_valid() && m_ready) begin
        got++;
        checks++; if (m_data !== q[0].data || m_last !== q[0].last) begin failures++; $display("[TB] FAIL wrap_beat got=%h/%0b exp=%h/%0b", m_data, m_last, q[0].data, q[0].last); end
      end
      acc = s_valid && exp_s_ready;
      tick();
      if (acc) begin s_valid = 1'b0; sent++; end
      cyc++;
    end
    m_ready = 1'b0;
    checks++; if (got !== 20) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=20", got); end
  endtask

`ifdef STREAM_FIFO_PKT_MODE_EN
  task automatic test_pkt_mode();
    int cyc = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h10 + 32'(i);
      s_last  = (i == 2);
      #1;
      checks++; if (m_valid !== 1'b0 || pkt_count !== 4'd0) begin failures++; $display("[TB] FAIL pkt_wait got=%0b/%0d exp=0/0", m_valid, pkt_count); end
      tick();
    end
    s_valid = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b1 || pkt_count !== 4'd1 || m_data !== 32'h10) begin failures++; $display("[TB] FAIL pkt_ready got=%0b/%0d/%h exp=1/1/10", m_valid, pkt_count, m_data); end
    while (q.size() != 0 && cyc < 10) begin
      #1;
      checks++; if (m_data !== q[0].data || m_last !== q[0].last) begin failures++; $display("[TB] FAIL pkt_beat got=%h/%0b exp=%h/%0b", m_data, m_last, q[0].data, q[0].last); end
      tick();
      cyc++;
    end
    checks++; if (pkt_count !== 4'd0 || m_valid !== 1'b0) begin failures++; $display("[TB] FAIL pkt_done got=%0d/%0b exp=0/0", pkt_count, m_valid); end
  endtask

  task automatic test_oversize();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int first_lvl = -1;
    logic acc;
    m_ready = 1'b1;
    while ((sent < 12 || q.size() != 0) && cyc < 80) begin
      s_valid = (sent < 12);
      s_data  = 32'hE0 + 32'(sent);
      s_last  = (sent == 11);
      #1;
      checks++; if (m_valid !== exp_m_valid()) begin failures++; $display("[TB] FAIL over_m_valid got=%0b exp=%0b", m_valid, exp_m_valid()); end
      if (m_valid && first_lvl < 0) first_lvl = int'(level);
      if (exp_m_valid()) begin
        got++;
        checks++; if (m_data !== q[0].data || m_last !== q[0].last) begin failures++; $display("[TB] FAIL over_beat got=%h/%0b exp=%h/%0b", m_data, m_last, q[0].data, q[0].last); end
      end
      acc = s_valid && exp_s_ready;
      tick();
      if (acc) sent++;
      cyc++;
    end
    s_valid = 1'b0;
    checks++; if (first_lvl !== 8) begin failures++; $display("[TB] FAIL over_first_level got=%0d exp=8", first_lvl); end
    checks++; if (got !== 12) begin failures++; $display("[TB] FAIL over_count got=%0d exp=12", got); end
  endtask
`endif

  task automatic test_mid_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hD0 + 32'(i);
      s_last  = (i == 4);
      tick();
    end
    s_valid = 1'b0;
    #1;
    checks++; if (level !== 4'd5) begin failures++; $display("[TB] FAIL pre_reset_level got=%0d exp=5", level); end
    rst_n = 1'b0;
    tick();
    checks++; if (level !== 4'd0 || m_valid !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset got=%0d/%0b/%0b exp=0/0/0", level, m_valid, s_ready); end
    checks++; if (pkt_count !== 4'd0) begin failures++; $display("[TB] FAIL mid_reset_pkt got=%0d exp=0", pkt_count); end
    rst_n = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_s_ready got=%0b exp=1", s_ready); end
    s_valid = 1'b1;
    s_data  = 32'hBEEF;
    s_last  = 1'b1;
    tick();
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'hBEEF || m_last !== 1'b1 || level !== 4'd1) begin failures++; $display("[TB] FAIL post_reset_head got=%0b/%h/%0b/%0d exp=1/beef/1/1", m_valid, m_data, m_last, level); end
    tick();
    checks++; if (level !== 4'd0 || m_valid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_drain got=%0d/%0b exp=0/0", level, m_valid); end
    m_ready = 1'b0;
  endtask

  initial begin
    $display("[TB] stream_fifo bench start");
    test_reset();
    test_smoke();
    test_fill_drain();
    test_wrap();
`ifdef STREAM_FIFO_PKT_MODE_EN
    test_pkt_mode();
    test_oversize();
`endif
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised multi-entry valid/ready stream FIFO carrying `data` plus a `last` packet delimiter; the next generation of the single-entry skid buffer on the audio sample path. It sits between the WAV sample source and the peak/RMS datapath, absorbing bursts and downstream stalls of up to `DEPTH` beats. An optional packet mode (store-and-forward) holds output until a complete packet is buffered.

## Interface
- `DATA_W`, default `stream_pkg::STREAM_DATA_W` (32): payload width.
- `DEPTH`, default 8: entry count; power of two, at least 2.
- `CNT_W`, derived `$clog2(DEPTH+1)`: width of the occupancy counters. Not overridable.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  upstream beat valid.
- `s_ready`  out  1  FIFO can accept; registered.
- `s_data`  in  DATA_W  upstream payload.
- `s_last`  in  1  final beat of a packet.
- `m_valid`  out  1  downstream beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_W  head payload.
- `m_last`  out  1  head beat's last flag.
- `level`  out  CNT_W  stored beats, 0..DEPTH.
- `pkt_count`  out  CNT_W  complete packets stored; constant 0 when packet mode is not compiled in.

## Operation
- Push when `s_valid && s_ready`; `{s_last, s_data}` is written at `wr_ptr`, which advances modulo DEPTH.
- Pop when `m_valid && m_ready`; `rd_ptr` advances modulo DEPTH.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Full and empty are decided by `level` only, never by pointer compare.
- `level_next = level + push - pop`. Simultaneous push and pop leave `level` unchanged.
- `s_ready` register: next value is `level_next < DEPTH`.
  - No combinational path from `m_ready` to `s_ready`.
  - When full, a pop frees the slot one cycle later.
- `m_data`/`m_last` read combinationally from the entry at `rd_ptr` (first-word fall-through). They are held stable while `m_valid && !m_ready`.
- Non-packet mode: `m_valid = (level != 0)`.
- Reset mid-operation: pointers, `level`, `pkt_count` and `s_ready` clear on the first edge with `rst_n` low. Stored contents are discarded without flush. Array contents are not reset.
- Reset values: `s_ready` 0, `m_valid` 0, `level` 0, `pkt_count` 0. `m_data`/`m_last` are don't-care while `m_valid` is 0.

## Timing
- Latency: a beat pushed at edge N is on `m_valid`/`m_data` after edge N, i.e. poppable at edge N+1.
- Throughput: one beat per cycle in both directions when not full and `m_ready` is high.
- After reset release, `s_ready` rises after the first edge with `rst_n` high.
- Full with `m_ready` high: one pop at edge N, `s_ready` high after edge N, push accepted at edge N+1. Sustained full-rate when full is not required.
- Upstream and downstream obey the standard rule: once asserted, `valid` holds with stable payload until the handshake completes.

## Configuration
- Macro: `STREAM_FIFO_PKT_MODE_EN`.
- Defined (store-and-forward):
  - `pkt_count` increments on a push with `s_last` and decrements on a pop with `m_last`; push-last plus pop-last in the same cycle leaves it unchanged.
  - `m_valid = (level != 0) && (pkt_count != 0 || level == DEPTH)`.
  - The `level == DEPTH` term is an oversize escape: a packet longer than DEPTH drains in cut-through fashion instead of deadlocking.
- Undefined: no packet counter logic; `pkt_count` tied to 0; `m_valid = (level != 0)`.

## Structure
- `stream_pkg` holds `STREAM_DATA_W = 32` and `typedef struct packed { logic [STREAM_DATA_W-1:0] data; logic last; } beat_t`. Benches use `beat_t` for scoreboards.
- The FIFO stores a flat `DATA_W+1` vector per entry, so non-default `DATA_W` works.
- One sub-module, `stream_fifo_mem`:
  - DEPTH×W register array.
  - One write port and one asynchronous read port.
  - Pointers, counters and `s_ready` stay in `stream_fifo`.

## Test plan
- No-stall smoke: packets of 3/1/5 beats from bases `0x1000/0x2000/0x3000`, `m_ready`=1 → 9 beats out in order with correct `last`; `level` ≤1 throughout.
- Fill and drain: `m_ready`=0, push 8 beats `0xA0..0xA7` → `level`=8, `s_ready`=0 on the next cycle, 9th beat held. Then `m_ready`=1 → `0xA0..0xA7` out, 9th beat accepted one cycle after the first pop.
- Wrap-around: 20 beats with random `m_ready` (50%) and `s_valid` (70%), DEPTH=8 → scoreboard exact match; `level` never exceeds 8.
- Packet mode: push 3 beats `0x10..0x12` with the last on `0x12`, `m_ready`=1 → `m_valid` stays 0 until the edge after `0x12` is pushed; `pkt_count` goes 0→1→0.
- Oversize packet, packet mode: 12-beat packet, DEPTH=8 → `m_valid` rises when `level`=8; all 12 beats delivered in order, no deadlock.
- Mid-stream reset: 5 beats stored, `rst_n` low for 1 cycle → `level`=0, `m_valid`=0, `s_ready`=0. After release, new beat `0xBEEF` is the first output.
